// File: rtl/alu_share_arbiter_if.sv
// Request/response and shared-ALU signal bundle for alu_share_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_share_arbiter_if;
    logic       ReqValid0, ReqValid1;
    logic       ReqReady0, ReqReady1;
    logic [3:0] ReqOp0, ReqOp1;
    logic [7:0] ReqA0, ReqA1, ReqB0, ReqB1;
    logic       RspValid0, RspValid1;
    logic       RspReady0, RspReady1;
    logic [7:0] RspData0, RspData1;
    logic       RspErr0, RspErr1;
    logic [3:0] ALUCon;
    logic [7:0] DataA, DataB;
    logic [7:0] Result;
    logic       Busy;

    modport slave (
        input  ReqValid0, ReqValid1, ReqOp0, ReqOp1, ReqA0, ReqA1, ReqB0, ReqB1,
        input  RspReady0, RspReady1, Result,
        output ReqReady0, ReqReady1, RspValid0, RspValid1, RspData0, RspData1,
        output RspErr0, RspErr1, ALUCon, DataA, DataB, Busy
    );

    modport master (
        output ReqValid0, ReqValid1, ReqOp0, ReqOp1, ReqA0, ReqA1, ReqB0, ReqB1,
        output RspReady0, RspReady1, Result,
        input  ReqReady0, ReqReady1, RspValid0, RspValid1, RspData0, RspData1,
        input  RspErr0, RspErr1, ALUCon, DataA, DataB, Busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one combinational 8-bit ALU: IDLE grants, EXEC drives
// the ALU for one cycle, RESP holds the result until the granted requester takes it.
module alu_share_arbiter #(
    parameter int OP_MAX     = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    alu_share_arbiter_if.slave bus
);
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state, state_nxt;
    logic                gnt0, gnt1, rsp_done;
    logic [3:0]          op_sel;
    logic [DATA_W-1:0]   a_sel, b_sel;

    logic [3:0]          alu_con_p0;
    logic [DATA_W-1:0]   a_p0, b_p0;
    logic                id_p0, ill_p0;
    logic [DATA_W-1:0]   res_p1;
    logic                err_p1;
    logic                last_id;

    function automatic logic is_illegal(input logic [3:0] op);
        return (int'(op) > OP_MAX);
    endfunction

    assign op_sel = gnt1 ? bus.ReqOp1 : bus.ReqOp0;
    assign a_sel  = gnt1 ? bus.ReqA1  : bus.ReqA0;
    assign b_sel  = gnt1 ? bus.ReqB1  : bus.ReqB0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // last_id=1 on contention hands the grant to requester 0 (round-robin).
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                gnt0 = bus.ReqValid0 & (~bus.ReqValid1 | FIXED_PRIO | last_id);
                gnt1 = bus.ReqValid1 & ~gnt0;
                if (gnt0 || gnt1) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_done = id_p0 ? bus.RspReady1 : bus.RspReady0;
                if (rsp_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: request capture at the grant edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_con_p0 <= '0;
            a_p0       <= '0;
            b_p0       <= '0;
            id_p0      <= 1'b0;
            ill_p0     <= 1'b0;
        end else if (gnt0 || gnt1) begin
            alu_con_p0 <= is_illegal(op_sel) ? 4'b0000 : op_sel;
            a_p0       <= a_sel;
            b_p0       <= b_sel;
            id_p0      <= gnt1;
            ill_p0     <= is_illegal(op_sel);
        end
    end

    // p1: result capture at the EXEC exit edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1  <= '0;
            err_p1  <= 1'b0;
            last_id <= 1'b1;
        end else begin
            if (state == EXEC) begin
                res_p1 <= ill_p0 ? '0 : bus.Result;
                err_p1 <= ill_p0;
            end
            if (rsp_done) last_id <= id_p0;
        end
    end

    assign bus.ReqReady0 = gnt0;
    assign bus.ReqReady1 = gnt1;
    assign bus.RspValid0 = (state == RESP) && !id_p0;
    assign bus.RspValid1 = (state == RESP) &&  id_p0;
    assign bus.RspData0  = bus.RspValid0 ? res_p1 : '0;
    assign bus.RspData1  = bus.RspValid1 ? res_p1 : '0;
    assign bus.RspErr0   = bus.RspValid0 & err_p1;
    assign bus.RspErr1   = bus.RspValid1 & err_p1;
    assign bus.ALUCon    = alu_con_p0;
    assign bus.DataA     = a_p0;
    assign bus.DataB     = b_p0;
    assign bus.Busy      = (state != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: round-robin instance plus a fixed-priority instance,
// each wired to a small ALU model (0000 AND, 0001 OR, 0010 ADD, 0110 SUB).
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if rr ();
    alu_share_arbiter_if fx ();

    alu_share_arbiter #(.OP_MAX(8), .FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(rr));
    alu_share_arbiter #(.OP_MAX(8), .FIXED_PRIO(1'b1)) dut_fx (.clk(clk), .rst_n(rst_n), .bus(fx));

    function automatic logic [7:0] alu_model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return 8'h00;
        endcase
    endfunction

    assign rr.Result = alu_model(rr.ALUCon, rr.DataA, rr.DataB);
    assign fx.Result = alu_model(fx.ALUCon, fx.DataA, fx.DataB);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit id, input bit v, input logic [3:0] op,
                             input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            rr.ReqValid1 = v; rr.ReqOp1 = op; rr.ReqA1 = a; rr.ReqB1 = b;
        end else begin
            rr.ReqValid0 = v; rr.ReqOp0 = op; rr.ReqA0 = a; rr.ReqB0 = b;
        end
    endtask

    // Single uncontended transaction on the round-robin instance, RspReady assumed high.
    task automatic txn(input bit id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_d, input bit exp_e, input string tag);
        drive_req(id, 1'b1, op, a, b);
        #1;
        chk({tag, "_rdy"}, id ? rr.ReqReady1 : rr.ReqReady0, 1);
        tick();
        drive_req(id, 1'b0, op, a, b);
        #1;
        chk({tag, "_exec_alucon"}, rr.ALUCon, exp_e ? 4'b0000 : op);
        chk({tag, "_exec_dataa"}, rr.DataA, a);
        chk({tag, "_exec_novalid"}, {rr.RspValid0, rr.RspValid1}, 0);
        tick();
        chk({tag, "_valid"}, id ? rr.RspValid1 : rr.RspValid0, 1);
        chk({tag, "_data"}, id ? rr.RspData1 : rr.RspData0, exp_d);
        chk({tag, "_err"}, id ? rr.RspErr1 : rr.RspErr0, exp_e);
        tick();
        chk({tag, "_valid_1cyc"}, {rr.RspValid0, rr.RspValid1}, 0);
        chk({tag, "_idle"}, rr.Busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        drive_req(0, 0, 4'h0, 8'h00, 8'h00);
        drive_req(1, 0, 4'h0, 8'h00, 8'h00);
        rr.RspReady0 = 0; rr.RspReady1 = 0;
        fx.ReqValid0 = 0; fx.ReqValid1 = 0; fx.ReqOp0 = 0; fx.ReqOp1 = 0;
        fx.ReqA0 = 0; fx.ReqA1 = 0; fx.ReqB0 = 0; fx.ReqB1 = 0;
        fx.RspReady0 = 0; fx.RspReady1 = 0;

        repeat (2) tick();
        chk("rst_busy", rr.Busy, 0);
        chk("rst_alucon", rr.ALUCon, 0);
        chk("rst_data", {rr.DataA, rr.DataB}, 0);
        chk("rst_rsp", {rr.RspValid0, rr.RspValid1, rr.RspData0, rr.RspData1, rr.RspErr0, rr.RspErr1}, 0);
        rst_n = 1'b1;

        // contention right after reset: requester 0 first
        rr.RspReady0 = 1; rr.RspReady1 = 1;
        drive_req(0, 1, 4'b0000, 8'h03, 8'h72);
        drive_req(1, 1, 4'b0001, 8'h0F, 8'hC2);
        #1;
        chk("c1_rdy0", rr.ReqReady0, 1);
        chk("c1_rdy1", rr.ReqReady1, 0);
        tick();
        drive_req(0, 0, 4'b0000, 8'h03, 8'h72);
        #1;
        chk("c1_busy", rr.Busy, 1);
        chk("c1_exec_rdy1", rr.ReqReady1, 0);
        tick();
        chk("c1_d0", rr.RspData0, 8'h02);
        chk("c1_v1_off", rr.RspValid1, 0);
        chk("c1_d1_off", rr.RspData1, 0);
        tick();
        chk("c1_rdy1_idle", rr.ReqReady1, 1);
        tick();
        chk("c1_exec_alucon1", rr.ALUCon, 4'b0001);
        tick();
        chk("c1_d1", rr.RspData1, 8'hCF);
        chk("c1_v0_off", rr.RspValid0, 0);
        tick();

        // repeat contention: requester 1 was last served, so requester 0 wins
        drive_req(0, 1, 4'b0000, 8'h03, 8'h72);
        #1;
        chk("c2_rdy0", rr.ReqReady0, 1);
        chk("c2_rdy1", rr.ReqReady1, 0);
        tick();
        drive_req(0, 0, 4'b0000, 8'h03, 8'h72);
        tick();
        chk("c2_d0", rr.RspData0, 8'h02);
        tick();
        tick();
        drive_req(1, 0, 4'b0001, 8'h0F, 8'hC2);
        tick();
        chk("c2_d1", rr.RspData1, 8'hCF);
        tick();
        chk("c2_idle", rr.Busy, 0);

        txn(0, 4'b0010, 8'hF3, 8'h02, 8'hF5, 1'b0, "add");

        // backpressure on requester 1; RspReady0 high must be ignored
        rr.RspReady1 = 0; rr.RspReady0 = 1;
        drive_req(1, 1, 4'b0110, 8'h07, 8'h02);
        drive_req(0, 1, 4'b0010, 8'h01, 8'h01);
        #1;
        chk("bp_rdy1", rr.ReqReady1, 1);
        chk("bp_rdy0", rr.ReqReady0, 0);
        tick();
        drive_req(1, 0, 4'b0110, 8'h07, 8'h02);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_v1", rr.RspValid1, 1);
            chk("bp_d1", rr.RspData1, 8'h05);
            chk("bp_rdy0_hold", rr.ReqReady0, 0);
            tick();
        end
        rr.RspReady1 = 1;
        #1;
        chk("bp_v1_last", rr.RspValid1, 1);
        tick();
        chk("bp_idle", rr.Busy, 0);
        chk("bp_rdy0_after", rr.ReqReady0, 1);
        drive_req(0, 0, 4'b0010, 8'h01, 8'h01);
        #1;
        chk("drop_rdy0", rr.ReqReady0, 0);
        tick();
        chk("drop_no_grant", rr.Busy, 0);

        txn(0, 4'b1010, 8'h55, 8'hAA, 8'h00, 1'b1, "ill");

        // reset during EXEC aborts the transaction
        drive_req(0, 1, 4'b0010, 8'h10, 8'h20);
        #1;
        tick();
        drive_req(0, 0, 4'b0010, 8'h10, 8'h20);
        #1;
        chk("mr_busy", rr.Busy, 1);
        chk("mr_alucon", rr.ALUCon, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("mr_busy_rst", rr.Busy, 0);
        chk("mr_alu_rst", {rr.ALUCon, rr.DataA, rr.DataB}, 0);
        chk("mr_rsp_rst", {rr.RspValid0, rr.RspData0, rr.RspErr0}, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_no_rsp", {rr.RspValid0, rr.RspValid1}, 0);
        end
        txn(1, 4'b0110, 8'h10, 8'h01, 8'h0F, 1'b0, "post_rst");

        // fixed priority: requester 0 wins every contention
        fx.RspReady0 = 1; fx.RspReady1 = 1;
        fx.ReqValid0 = 1; fx.ReqOp0 = 4'b0010; fx.ReqA0 = 8'h01; fx.ReqB0 = 8'h01;
        fx.ReqValid1 = 1; fx.ReqOp1 = 4'b0001; fx.ReqA1 = 8'h30; fx.ReqB1 = 8'h03;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fx_rdy0", fx.ReqReady0, 1);
            chk("fx_rdy1", fx.ReqReady1, 0);
            tick();
            tick();
            chk("fx_v0", fx.RspValid0, 1);
            chk("fx_d0", fx.RspData0, 8'h02);
            tick();
        end
        fx.ReqValid0 = 0;
        #1;
        chk("fx_rdy1_alone", fx.ReqReady1, 1);
        tick();
        fx.ReqValid1 = 0;
        tick();
        chk("fx_d1", fx.RspData1, 8'h33);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
